// File: rtl/register_bank.sv
// register_bank
//   Small general-purpose register file with a built-in single-operand ALU.
//   Each rising edge with n_load_i low applies one operation (load, increment,
//   decrement, shifts, rotate, clear, no-op) to register wr_addr_i. Carry and
//   zero flags describe the last executed operation. Two registered read ports
//   see the value written on the same edge (write-to-read bypass). Port A can
//   also be driven onto an output bus, gated by n_enable_i.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous, active-high reset
//   n_load_i     execute op_i on register wr_addr_i this edge (active-low)
//   op_i         operation select
//   wr_addr_i    target register of the executed operation
//   bus_in_i     data source for LOAD
//   rd_addr_a_i  read-port A address
//   rd_addr_b_i  read-port B address
//   n_enable_i   drive value_a_o onto bus_out_o (active-low)
//   value_a_o    registered read-port A data
//   value_b_o    registered read-port B data
//   bus_out_o    value_a_o when enabled, otherwise all-zero
//   bus_oe_o     bus output enable, inverse of n_enable_i
//   cf_o         carry/borrow flag of the last executed operation
//   zf_o         zero flag of the last executed operation
module register_bank #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              n_load_i,
  input  logic [2:0]        op_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  bus_in_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  input  logic              n_enable_i,
  output logic [WIDTH-1:0]  value_a_o,
  output logic [WIDTH-1:0]  value_b_o,
  output logic [WIDTH-1:0]  bus_out_o,
  output logic              bus_oe_o,
  output logic              cf_o,
  output logic              zf_o
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] value_a_q, value_a_d;
  logic [WIDTH-1:0] value_b_q, value_b_d;
  logic             cf_q, cf_d;
  logic             zf_q, zf_d;

  logic [WIDTH-1:0] old_s;
  logic [WIDTH-1:0] res_s;
  logic             cf_res_s;
  logic             exec_s;

  // ALU: result and carry of op_i applied to the currently addressed register.
  always_comb begin
    old_s    = regs_q[wr_addr_i];
    res_s    = old_s;
    cf_res_s = 1'b0;
    case (op_i)
      OP_LOAD: begin
        res_s    = bus_in_i;
        cf_res_s = 1'b0;
      end
      OP_INC: begin
        res_s    = old_s + ONE_C;
        cf_res_s = (old_s == ONES_C);
      end
      OP_DEC: begin
        res_s    = old_s - ONE_C;
        cf_res_s = (old_s == ZERO_C);
      end
      OP_SHL: begin
        res_s    = {old_s[WIDTH-2:0], 1'b0};
        cf_res_s = old_s[WIDTH-1];
      end
      OP_SHR: begin
        res_s    = {1'b0, old_s[WIDTH-1:1]};
        cf_res_s = old_s[0];
      end
      OP_CLR: begin
        res_s    = ZERO_C;
        cf_res_s = 1'b0;
      end
      OP_ROL: begin
        res_s    = {old_s[WIDTH-2:0], old_s[WIDTH-1]};
        cf_res_s = old_s[WIDTH-1];
      end
      OP_NOP: begin
        res_s    = old_s;
        cf_res_s = 1'b0;
      end
      default: begin
        res_s    = old_s;
        cf_res_s = 1'b0;
      end
    endcase
  end

  // NOP is treated as "not executed" so it leaves both register and flags alone.
  assign exec_s = ~n_load_i & (op_i != OP_NOP);

  // Next-state of the register file and flags; read ports see the post-write
  // file so a same-edge write is bypassed to both ports.
  always_comb begin
    regs_d = regs_q;
    cf_d   = cf_q;
    zf_d   = zf_q;
    if (exec_s) begin
      regs_d[wr_addr_i] = res_s;
      cf_d              = cf_res_s;
      zf_d              = (res_s == ZERO_C);
    end else begin
      regs_d = regs_q;
    end
    value_a_d = regs_d[rd_addr_a_i];
    value_b_d = regs_d[rd_addr_b_i];
  end

  // State registers; reset clears everything asynchronously and zf reads as 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= ZERO_C;
      end
      value_a_q <= ZERO_C;
      value_b_q <= ZERO_C;
      cf_q      <= 1'b0;
      zf_q      <= 1'b1;
    end else begin
      regs_q    <= regs_d;
      value_a_q <= value_a_d;
      value_b_q <= value_b_d;
      cf_q      <= cf_d;
      zf_q      <= zf_d;
    end
  end

  assign value_a_o = value_a_q;
  assign value_b_o = value_b_q;
  assign cf_o      = cf_q;
  assign zf_o      = zf_q;

  // Output bus is a plain gated copy of port A; no internal tri-state.
  assign bus_oe_o  = ~n_enable_i;
  assign bus_out_o = n_enable_i ? ZERO_C : value_a_q;

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int ADDR_W = 2;
  localparam int M = 1 << WIDTH;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              n_load = 1'b1;
  logic [2:0]        op = 3'd7;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [WIDTH-1:0]  bus_in = '0;
  logic [ADDR_W-1:0] rd_addr_a = '0;
  logic [ADDR_W-1:0] rd_addr_b = '0;
  logic              n_enable = 1'b1;
  logic [WIDTH-1:0]  value_a, value_b, bus_out;
  logic              bus_oe, cf, zf;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .n_load_i(n_load), .op_i(op), .wr_addr_i(wr_addr),
    .bus_in_i(bus_in), .rd_addr_a_i(rd_addr_a), .rd_addr_b_i(rd_addr_b),
    .n_enable_i(n_enable), .value_a_o(value_a), .value_b_o(value_b),
    .bus_out_o(bus_out), .bus_oe_o(bus_oe), .cf_o(cf), .zf_o(zf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents as integers, ops as plain arithmetic.
  int m_reg [DEPTH];
  int m_va = 0, m_vb = 0, m_cf = 0, m_zf = 1;
  int m_old, m_new, m_c, m_t;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_reg[i] = 0;
      m_va = 0; m_vb = 0; m_cf = 0; m_zf = 1;
    end else begin
      if (!n_load && op != 3'd7) begin
        m_old = m_reg[wr_addr];
        m_new = m_old;
        m_c = 0;
        case (op)
          3'd0: begin m_new = bus_in; m_c = 0; end
          3'd1: begin m_t = m_old + 1; m_c = (m_t >= M); m_new = m_t % M; end
          3'd2: begin m_t = m_old - 1; m_c = (m_t < 0); m_new = (m_t + M) % M; end
          3'd3: begin m_t = m_old * 2; m_c = (m_t >= M); m_new = m_t % M; end
          3'd4: begin m_c = m_old % 2; m_new = m_old / 2; end
          3'd5: begin m_new = 0; m_c = 0; end
          3'd6: begin m_c = (m_old >= M / 2); m_new = (m_old * 2) % M + m_c; end
          default: ;
        endcase
        m_reg[wr_addr] = m_new;
        m_cf = m_c;
        m_zf = (m_new == 0);
      end
      m_va = m_reg[rd_addr_a];
      m_vb = m_reg[rd_addr_b];
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("value_a", value_a, m_va);
      chk("value_b", value_b, m_vb);
      chk("cf", cf, m_cf);
      chk("zf", zf, m_zf);
      chk("bus_oe", bus_oe, n_enable ? 0 : 1);
      chk("bus_out", bus_out, n_enable ? 0 : m_va);
    end
  end

  // Drive one cycle's inputs, let the edge pass, sample 1 time unit later.
  task automatic do_op(input logic nl, input logic [2:0] o, input int wa,
                       input int din, input int ra, input int rb);
    n_load = nl; op = o; wr_addr = ADDR_W'(wa); bus_in = WIDTH'(din);
    rd_addr_a = ADDR_W'(ra); rd_addr_b = ADDR_W'(rb);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_reg[i] = 0;
    #1 rst = 1'b1;
    #1;
    chk("reset value_a", value_a, 0);
    chk("reset value_b", value_b, 0);
    chk("reset cf", cf, 0);
    chk("reset zf", zf, 1);
    started = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Load with same-edge read of the written register
    do_op(1'b0, 3'd0, 2, 'hA5, 2, 0);
    chk("load A5 value_a", value_a, 'hA5);
    chk("load A5 cf", cf, 0);
    chk("load A5 zf", zf, 0);

    // Wrap on INC, borrow on DEC
    do_op(1'b0, 3'd0, 1, 'hFF, 1, 0);
    do_op(1'b0, 3'd1, 1, 0, 1, 0);
    chk("inc FF value", value_a, 'h00);
    chk("inc FF cf", cf, 1);
    chk("inc FF zf", zf, 1);
    do_op(1'b0, 3'd2, 1, 0, 1, 0);
    chk("dec 00 value", value_a, 'hFF);
    chk("dec 00 cf", cf, 1);
    chk("dec 00 zf", zf, 0);

    // Shifts and rotate of 0x81
    do_op(1'b0, 3'd0, 0, 'h81, 0, 0);
    do_op(1'b0, 3'd3, 0, 0, 0, 0);
    chk("shl 81", value_a, 'h02);
    chk("shl cf", cf, 1);
    do_op(1'b0, 3'd0, 0, 'h81, 0, 0);
    do_op(1'b0, 3'd6, 0, 0, 0, 0);
    chk("rol 81", value_a, 'h03);
    chk("rol cf", cf, 1);
    do_op(1'b0, 3'd0, 0, 'h81, 0, 0);
    do_op(1'b0, 3'd4, 0, 0, 0, 0);
    chk("shr 81", value_a, 'h40);
    chk("shr cf", cf, 1);

    // n_load high with CLR must not touch register or flags
    do_op(1'b0, 3'd0, 3, 'h3C, 3, 0);
    do_op(1'b0, 3'd3, 2, 0, 3, 2);   // r2 A5 -> 4A, cf=1
    chk("shl A5", value_b, 'h4A);
    for (int k = 0; k < 4; k++) begin
      do_op(1'b1, 3'd5, 3, 0, 3, 2);
      chk("hold r3", value_a, 'h3C);
      chk("hold cf", cf, 1);
      chk("hold zf", zf, 0);
    end
    // NOP executed keeps flags and register
    do_op(1'b0, 3'd7, 3, 0, 3, 2);
    chk("nop r3", value_a, 'h3C);
    chk("nop cf", cf, 1);

    // Two read ports and output bus
    do_op(1'b0, 3'd0, 0, 'h11, 0, 0);
    do_op(1'b0, 3'd0, 1, 'h22, 0, 1);
    n_enable = 1'b0;
    do_op(1'b1, 3'd7, 0, 0, 0, 1);
    chk("port a", value_a, 'h11);
    chk("port b", value_b, 'h22);
    chk("bus_out en", bus_out, 'h11);
    chk("bus_oe en", bus_oe, 1);
    rd_addr_a = 2'd1;
    #1;
    chk("no comb read", value_a, 'h11);
    n_enable = 1'b1;
    #1;
    chk("bus_out dis", bus_out, 'h00);
    chk("bus_oe dis", bus_oe, 0);

    // Double bypass to both ports on the same register
    do_op(1'b0, 3'd0, 2, 'h77, 2, 2);
    chk("bypass a", value_a, 'h77);
    chk("bypass b", value_b, 'h77);

    // Asynchronous reset mid-sequence
    do_op(1'b0, 3'd0, 0, 'h5A, 0, 2);
    chk("load 5A", value_a, 'h5A);
    n_load = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async value_a", value_a, 0);
    chk("async zf", zf, 1);
    chk("async cf", cf, 0);
    n_enable = 1'b0;
    #1;
    chk("rst bus_out", bus_out, 0);
    chk("rst bus_oe", bus_oe, 1);
    do_op(1'b0, 3'd0, 0, 'h99, 0, 0);
    chk("load in rst", value_a, 0);
    rst = 1'b0;
    do_op(1'b0, 3'd0, 0, 'h99, 0, 1);
    chk("first edge after rst", value_a, 'h99);
    chk("r1 cleared", value_b, 0);
    do_op(1'b1, 3'd7, 0, 0, 2, 3);
    chk("r2 cleared", value_a, 0);
    chk("r3 cleared", value_b, 0);

    // DEC from 0 and CLR flags
    do_op(1'b0, 3'd2, 1, 0, 1, 0);
    chk("dec 0", value_a, 'hFF);
    chk("dec 0 cf", cf, 1);
    do_op(1'b0, 3'd5, 1, 0, 1, 0);
    chk("clr", value_a, 0);
    chk("clr cf", cf, 0);
    chk("clr zf", zf, 1);

    @(negedge clk);
    started = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter WIDTH, default 8, data width of every register and of the bus (legal range 4..16).
REQ-002 Parameter DEPTH, default 4, number of registers (power of two, 2..16).
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), register address width.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 n_load  input  1  execute op on register wr_addr this edge (ACTIVE-LOW).
REQ-007 op  input  3  operation select (see REQ-013).
REQ-008 wr_addr  input  ADDR_W  target register of the executed op.
REQ-009 bus_in  input  WIDTH  data source for LOAD.
REQ-010 rd_addr_a, rd_addr_b  input  ADDR_W each  read-port addresses.
REQ-011 value_a, value_b  output  WIDTH each  registered read-port data (to ALU).
REQ-012 n_enable  input  1  drive value_a onto bus_out (ACTIVE-LOW); bus_out  output  WIDTH; bus_oe  output  1; cf  output  1 carry/borrow flag; zf  output  1 zero flag.

Function
REQ-013 op encoding: 000 LOAD (bus_in), 001 INC (+1), 010 DEC (-1), 011 SHL (0 shifted in at LSB), 100 SHR (0 shifted in at MSB), 101 CLR, 110 ROL (MSB into LSB), 111 NOP.
REQ-014 With n_load=0 at a rising edge, register wr_addr SHALL take the op result; all other registers unchanged.
REQ-015 With n_load=1, no register, cf or zf SHALL change, regardless of op.
REQ-016 All arithmetic SHALL be modulo 2^WIDTH: INC of all-ones -> 0, DEC of 0 -> all-ones.
REQ-017 cf SHALL update on every executed op except NOP: INC cf=1 only on wrap to 0; DEC cf=1 only on borrow from 0; SHL/ROL cf=old MSB; SHR cf=old LSB; LOAD/CLR cf=0.
REQ-018 zf SHALL update on every executed op except NOP: zf=1 iff the new register value is 0.
REQ-019 NOP with n_load=0 SHALL leave registers and flags unchanged.
REQ-020 Read latency one cycle: at each rising edge value_a <= register[rd_addr_a], value_b <= register[rd_addr_b], sampled after that edge's write (write-to-read bypass).
REQ-021 Bypass SHALL apply independently to both ports, including rd_addr_a == rd_addr_b == wr_addr.
REQ-022 Read address changes SHALL appear on value_a/value_b only after the next rising edge, never combinationally.
REQ-023 bus_oe SHALL equal ~n_enable combinationally; bus_out SHALL equal value_a when n_enable=0, else all-zero (no internal tri-state).
REQ-024 Flags reflect the last executed op only, not the register currently read.

Reset
REQ-025 rst=1 SHALL immediately, without clock, set all registers, value_a, value_b to 0, cf=0, zf=1.
REQ-026 While rst=1, n_load and op SHALL be ignored; bus_out/bus_oe still follow REQ-023 (bus_out 0 when enabled).
REQ-027 Deassertion of rst SHALL take effect so the first rising edge after release executes a pending op normally.
REQ-028 Assertion of rst mid-sequence SHALL discard any op on that edge; no partial update.

Verification
REQ-029 Reset then LOAD 0xA5 into r2 (n_load=0, op=000, wr_addr=2), rd_addr_a=2 same edge -> value_a=0xA5 after that edge, cf=0, zf=0.
REQ-030 LOAD 0xFF into r1, then INC r1 -> r1=0x00, cf=1, zf=1; then DEC r1 -> r1=0xFF, cf=1, zf=0.
REQ-031 LOAD 0x81 into r0, SHL -> 0x02 cf=1; ROL of 0x81 -> 0x03 cf=1; SHR of 0x81 -> 0x40 cf=1.
REQ-032 n_load=1 with op=101 on r3 holding 0x3C for 4 cycles -> r3 stays 0x3C, flags unchanged.
REQ-033 r0=0x11, r1=0x22; rd_addr_a=0, rd_addr_b=1, n_enable=0 -> after one edge value_a=0x11, value_b=0x22, bus_out=0x11, bus_oe=1; n_enable=1 -> bus_out=0x00, bus_oe=0.
REQ-034 Assert rst between clock edges after loading 0x5A -> value_a, all registers 0, zf=1 immediately; clock edge with LOAD during rst has no effect.
